// File: rtl/layer_mac_sequencer_pkg.sv
// rtl/layer_mac_sequencer_pkg.sv - shared types, widths and result-shaping helpers for the layer MAC sequencer
package layer_mac_sequencer_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_e;

  // Index width that never collapses to zero bits for tiny layers
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

  // Clamp a wide signed accumulator into the DW-bit two's complement range
  function automatic logic [DW-1:0] saturate(input logic signed [63:0] x);
    if (x > SAT_MAX) return {1'b0, {(DW - 1){1'b1}}};
    if (x < SAT_MIN) return {1'b1, {(DW - 1){1'b0}}};
    return x[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/layer_mac_sequencer_if.sv
// rtl/layer_mac_sequencer_if.sv - weight ROM, activation buffer and result stream bundle
interface layer_mac_sequencer_if #(
  parameter int DW = 16,
  parameter int WA = 9,
  parameter int AW = 4,
  parameter int RW = 5
);
  logic [WA-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] act_idx;
  logic [DW-1:0] act_data;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_idx;
  logic          res_valid;
  logic          res_ready;

  modport master (
    output w_addr, act_idx, res_data, res_idx, res_valid,
    input  w_data, act_data, res_ready
  );

  modport slave (
    input  w_addr, act_idx, res_data, res_idx, res_valid,
    output w_data, act_data, res_ready
  );
endinterface

// File: rtl/layer_mac_sequencer_mac_unit.sv
// rtl/layer_mac_sequencer_mac_unit.sv - registered multiply-accumulate; LAYER_MAC_SAT_EN selects wide saturating mode
module mac_unit
  import layer_mac_sequencer_pkg::*;
#(
  parameter int ACC_W = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] res_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

`ifdef LAYER_MAC_SAT_EN
  logic signed [2*DW-1:0] prod;
  logic signed [63:0]     acc_ext;

  // Full-precision accumulate; res_o already reflects this cycle's update so DRAIN can capture it
  always_comb begin
    prod    = $signed(a) * $signed(w);
    acc_d   = acc_q;
    if (load)    acc_d = ACC_W'($signed(w));
    else if (en) acc_d = acc_q + ACC_W'(prod);
    acc_ext = 64'(acc_d);
    res_o   = relu(saturate(acc_ext));
  end
`else
  // Modular DW-bit accumulate, bit-compatible with the parallel node blocks
  always_comb begin
    acc_d = acc_q;
    if (load)    acc_d = ACC_W'(w);
    else if (en) acc_d = acc_q + ACC_W'(a * w);
    res_o = relu(acc_d);
  end
`endif

  // Accumulator register
  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// rtl/layer_mac_sequencer.sv - one shared MAC sequenced over all neurons of a dense layer; option LAYER_MAC_SAT_EN
module layer_mac_sequencer
  import layer_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS  = 15,
  parameter int N_NEURONS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  layer_mac_sequencer_if.master bus
);

  localparam int WA = width_of(N_NEURONS * (N_INPUTS + 1));
  localparam int AW = width_of(N_INPUTS);
  localparam int RW = width_of(N_NEURONS);
  localparam int KW = width_of(N_INPUTS + 1);
`ifdef LAYER_MAC_SAT_EN
  localparam int ACC_W = 2 * DW + width_of(N_INPUTS + 1);
`else
  localparam int ACC_W = DW;
`endif

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] n_q, n_d;
  logic [WA-1:0] base_q, base_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [RW-1:0] res_idx_q, res_idx_d;
  logic          tag_vld_q, tag_zero_q;
  logic [DW-1:0] mac_res;

  // Row base tracks n*(N_INPUTS+1) incrementally; word k of the row is bias (k=0) or weight k-1
  assign bus.w_addr    = base_q + WA'(k_q);
  assign bus.act_idx   = (k_q == '0) ? '0 : AW'(k_q - KW'(1));
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_valid = res_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Fetch data returns one cycle after the address, so the MAC works on the delayed tag
  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .load  (tag_vld_q & tag_zero_q),
    .en    (tag_vld_q & ~tag_zero_q),
    .a     (bus.act_data),
    .w     (bus.w_data),
    .res_o (mac_res)
  );

  // Next-state: sequencing of fetch counters, neuron index and result handshake
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          n_d     = '0;
          base_d  = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (k_q == KW'(N_INPUTS)) state_d = DRAIN;
        else                      k_d     = k_q + KW'(1);
      end
      DRAIN: begin
        res_data_d  = mac_res;
        res_idx_d   = n_q;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          k_d         = '0;
          if (n_q == RW'(N_NEURONS - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            n_d     = '0;
            base_d  = '0;
            state_d = IDLE;
          end else begin
            n_d     = n_q + RW'(1);
            base_d  = base_q + WA'(N_INPUTS + 1);
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, tag pipeline and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      tag_vld_q   <= 1'b0;
      tag_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      tag_vld_q   <= (state_q == RUN);
      tag_zero_q  <= (k_q == '0);
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb/tb_layer_mac_sequencer.sv - directed bench for layer_mac_sequencer with N_INPUTS=3, N_NEURONS=2
module tb_layer_mac_sequencer;
  import layer_mac_sequencer_pkg::*;

  localparam int NI = 3;
  localparam int NN = 2;
  localparam int WA = width_of(NN * (NI + 1));
  localparam int AW = width_of(NI);
  localparam int RW = width_of(NN);

`ifdef LAYER_MAC_SAT_EN
  localparam logic [DW-1:0] T3_EXP = 16'h7FFF;
`else
  localparam logic [DW-1:0] T3_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  int tests = 0;
  int failed = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs_snap;
  int done_snap;

  logic [DW-1:0] rom [0:7];
  logic [DW-1:0] act [0:3];

  layer_mac_sequencer_if #(.DW(DW), .WA(WA), .AW(AW), .RW(RW)) bus_if ();

  layer_mac_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Registered-read memories plus handshake/done counters
  always @(posedge clk) begin
    bus_if.w_data   <= rom[bus_if.w_addr];
    bus_if.act_data <= act[bus_if.act_idx];
    if (bus_if.res_valid && bus_if.res_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_valid"}, 32'(bus_if.res_valid), 0);
    chk({tag, "_data"},  32'(bus_if.res_data), 0);
    chk({tag, "_idx"},   32'(bus_if.res_idx), 0);
    chk({tag, "_waddr"}, 32'(bus_if.w_addr), 0);
    chk({tag, "_aidx"},  32'(bus_if.act_idx), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus_if.res_ready = 1'b1;
    rom[0] = 16'd1;  rom[1] = 16'd2;  rom[2] = 16'hFFFF; rom[3] = 16'd3;
    rom[4] = 16'hFFF6; rom[5] = 16'd0; rom[6] = 16'd0;  rom[7] = 16'd0;
    act[0] = 16'd4;  act[1] = 16'd5;  act[2] = 16'd6;   act[3] = 16'd0;

    step(3);
    chk_all_zero("reset");
    reset = 1'b1;
    step(1);

    // T1: neuron 0 = 1 + 2*4 - 5 + 3*6 = 22, valid 6 cycles after start
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_waddr_k0", 32'(bus_if.w_addr), 0);
    step(2);
    chk("t1_waddr_k2", 32'(bus_if.w_addr), 2);
    chk("t1_aidx_k2", 32'(bus_if.act_idx), 1);
    step(2);
    chk("t1_valid_early", 32'(bus_if.res_valid), 0);
    step(1);
    chk("t1_valid", 32'(bus_if.res_valid), 1);
    chk("t1_data", 32'(bus_if.res_data), 22);
    chk("t1_idx", 32'(bus_if.res_idx), 0);
    step(1);
    chk("t1_valid_drop", 32'(bus_if.res_valid), 0);
    chk("t1_waddr_n1", 32'(bus_if.w_addr), 4);

    // T2: neuron 1 = -10 -> ReLU 0, done with the final handshake
    step(5);
    chk("t2_valid", 32'(bus_if.res_valid), 1);
    chk("t2_data", 32'(bus_if.res_data), 0);
    chk("t2_idx", 32'(bus_if.res_idx), 1);
    chk("t2_done_early", 32'(done), 0);
    step(1);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy_low", 32'(busy), 0);
    chk("t2_valid_low", 32'(bus_if.res_valid), 0);

    // T3/T4: restart on the done cycle, overflowing product, then backpressure
    rom[0] = 16'd0; rom[1] = 16'd4; rom[2] = 16'd0; rom[3] = 16'd0;
    act[0] = 16'h4000;
    start = 1'b1;
    bus_if.res_ready = 1'b0;
    step(1);
    start = 1'b0;
    hs_snap = hs_cnt;
    done_snap = done_cnt;
    chk("t2_done_pulse", 32'(done), 0);
    chk("t3_restart_busy", 32'(busy), 1);
    step(5);
    chk("t3_valid", 32'(bus_if.res_valid), 1);
    chk("t3_data", 32'(bus_if.res_data), 32'(T3_EXP));
    chk("t3_idx", 32'(bus_if.res_idx), 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_hold_valid", 32'(bus_if.res_valid), 1);
      chk("t4_hold_data", 32'(bus_if.res_data), 32'(T3_EXP));
      chk("t4_hold_idx", 32'(bus_if.res_idx), 0);
      chk("t4_hold_waddr", 32'(bus_if.w_addr), 3);
    end
    step(1);
    chk("t4_hold_waddr_last", 32'(bus_if.w_addr), 3);
    bus_if.res_ready = 1'b1;
    step(1);
    chk("t4_valid_drop", 32'(bus_if.res_valid), 0);
    chk("t4_resume_waddr", 32'(bus_if.w_addr), 4);

    // T5: start pulse during RUN must not disturb the layer
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t5_waddr_k2", 32'(bus_if.w_addr), 6);
    step(3);
    chk("t5_valid", 32'(bus_if.res_valid), 1);
    chk("t5_data", 32'(bus_if.res_data), 0);
    chk("t5_idx", 32'(bus_if.res_idx), 1);
    step(1);
    chk("t5_done", 32'(done), 1);
    step(9);
    chk("t5_results", 32'(hs_cnt - hs_snap), 2);
    chk("t5_dones", 32'(done_cnt - done_snap), 1);
    chk("t5_idle", 32'(busy), 0);

    // T6: reset mid-RUN aborts, then a fresh layer reproduces T1
    rom[0] = 16'd1; rom[1] = 16'd2; rom[2] = 16'hFFFF; rom[3] = 16'd3;
    act[0] = 16'd4;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    chk_all_zero("t6_abort");
    reset = 1'b1;
    hs_snap = hs_cnt;
    done_snap = done_cnt;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    chk("t6_valid", 32'(bus_if.res_valid), 1);
    chk("t6_data", 32'(bus_if.res_data), 22);
    chk("t6_idx", 32'(bus_if.res_idx), 0);
    step(6);
    chk("t6_n1_valid", 32'(bus_if.res_valid), 1);
    chk("t6_n1_idx", 32'(bus_if.res_idx), 1);
    step(1);
    chk("t6_done", 32'(done), 1);
    step(2);
    chk("t6_results", 32'(hs_cnt - hs_snap), 2);
    chk("t6_dones", 32'(done_cnt - done_snap), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
